// File: rtl/dmem_pkg.sv
// Types and helpers local to the dmem_responder block.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    localparam int unsigned CNT_W = 4;

    // Byte address to word index; the caller truncates to its array depth.
    function automatic logic [31:0] word_index(input logic [31:0] addr);
        return addr >> 2;
    endfunction

endpackage

// File: rtl/mem_pkg.sv
// Common data-memory request types shared by the memory stage and its responders.
package mem_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;

    typedef logic [DATA_W-1:0] word_t;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [1:0]        size;
    } mem_read_req;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [1:0]        size;
        word_t             data;
        logic [STRB_W-1:0] strobe;
    } mem_write_req;

endpackage

// File: rtl/dmem_array.sv
// WORDS x 32 storage with byte-strobed synchronous write and a read-before-write
// registered read port; only the read register is reset.
module dmem_array
    import mem_pkg::*;
#(
    parameter int unsigned WORDS = 1024
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we_i,
    input  logic                     re_i,
    input  logic [$clog2(WORDS)-1:0] idx_i,
    input  word_t                    wdata_i,
    input  logic [STRB_W-1:0]        wstrb_i,
    output word_t                    rdata_o
);

    word_t mem_q [WORDS];
    word_t rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int i = 0; i < int'(STRB_W); i++) begin
                if (wstrb_i[i]) begin
                    mem_q[idx_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
    end

    // Nonblocking read sees the array contents from before a same-edge write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: serves held pipeline requests after LATENCY wait states.
// Optional DMEM_OOR_ERR_EN flags and suppresses out-of-range addresses via addr_err.
module dmem_responder
    import mem_pkg::*;
    import dmem_pkg::*;
#(
    parameter int unsigned WORDS   = 1024,
    parameter int unsigned LATENCY = 2
) (
    input  logic         clk,
    input  logic         resetn,
    input  mem_read_req  mread,
    input  mem_write_req mwrite,
    input  logic         advance,
    output word_t        rd,
    output logic         stall
`ifdef DMEM_OOR_ERR_EN
    ,
    output logic         addr_err
`endif
);

    localparam int unsigned IDX_W = $clog2(WORDS);

    dmem_state_t       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              req_c;
    logic              access_c;
    logic              oor_c;
    logic              we_c;
    logic              re_c;
    logic [ADDR_W-1:0] addr_c;
    logic [IDX_W-1:0]  idx_c;
    logic              unused_c;

    // A valid write takes priority over a simultaneous read.
    assign req_c  = mread.valid | mwrite.valid;
    assign addr_c = mwrite.valid ? mwrite.addr : mread.addr;
    assign idx_c  = IDX_W'(word_index(addr_c));

`ifdef DMEM_OOR_ERR_EN
    assign oor_c = |(addr_c >> (IDX_W + 2));
`else
    assign oor_c = 1'b0;
`endif

    assign unused_c = ^{mread.size, mwrite.size};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        access_c = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_c) begin
                    cnt_d = CNT_W'(LATENCY - 1);
                    if (LATENCY == 1) begin
                        access_c = 1'b1;
                        state_d  = RESP;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!req_c) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_W'(1)) begin
                    access_c = 1'b1;
                    state_d  = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (advance) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign we_c  = access_c & mwrite.valid & ~oor_c;
    assign re_c  = access_c & ~mwrite.valid & ~oor_c;
    assign stall = req_c & (state_q != RESP);

    dmem_array #(
        .WORDS(WORDS)
    ) u_array (
        .clk    (clk),
        .rst_n  (resetn),
        .we_i   (we_c),
        .re_i   (re_c),
        .idx_i  (idx_c),
        .wdata_i(mwrite.data),
        .wstrb_i(mwrite.strobe),
        .rdata_o(rd)
    );

`ifdef DMEM_OOR_ERR_EN
    logic addr_err_q, addr_err_d;

    always_comb begin
        addr_err_d = addr_err_q;
        if (access_c) begin
            addr_err_d = oor_c;
        end else if ((state_q == RESP) && advance) begin
            addr_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            addr_err_q <= 1'b0;
        end else begin
            addr_err_q <= addr_err_d;
        end
    end

    assign addr_err = addr_err_q;
`endif

    // The requester must hold its request unchanged while waiting in RESP.
    property p_resp_hold;
        @(posedge clk) disable iff (!resetn)
            ((state_q == RESP) && !advance) |=> ($stable(mread) && $stable(mwrite));
    endproperty
    a_resp_hold: assert property (p_resp_hold);

endmodule

// File: tb/tb_dmem_responder.sv
// Randomised self-checking bench: three responders (LATENCY 1, 2, 4) against a word-array model.
`timescale 1ns/1ps
module tb_dmem_responder;
    import mem_pkg::*;

    localparam int unsigned WORDS = 1024;

    logic         clk;
    logic         resetn;
    mem_read_req  mread_s   [3];
    mem_write_req mwrite_s  [3];
    logic         advance_s [3];
    word_t        rd_s      [3];
    logic         stall_s   [3];
`ifdef DMEM_OOR_ERR_EN
    logic         addr_err_s [3];
`endif

    int    n_vec;
    int    n_err;
    word_t mdl [int];
    word_t rd_last [3];

    dmem_responder #(.WORDS(WORDS), .LATENCY(1)) u_lat1 (
        .clk(clk), .resetn(resetn), .mread(mread_s[0]), .mwrite(mwrite_s[0]),
        .advance(advance_s[0]), .rd(rd_s[0]), .stall(stall_s[0])
`ifdef DMEM_OOR_ERR_EN
        , .addr_err(addr_err_s[0])
`endif
    );

    dmem_responder #(.WORDS(WORDS), .LATENCY(2)) u_lat2 (
        .clk(clk), .resetn(resetn), .mread(mread_s[1]), .mwrite(mwrite_s[1]),
        .advance(advance_s[1]), .rd(rd_s[1]), .stall(stall_s[1])
`ifdef DMEM_OOR_ERR_EN
        , .addr_err(addr_err_s[1])
`endif
    );

    dmem_responder #(.WORDS(WORDS), .LATENCY(4)) u_lat4 (
        .clk(clk), .resetn(resetn), .mread(mread_s[2]), .mwrite(mwrite_s[2]),
        .advance(advance_s[2]), .rd(rd_s[2]), .stall(stall_s[2])
`ifdef DMEM_OOR_ERR_EN
        , .addr_err(addr_err_s[2])
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lat_of(input int u);
        case (u)
            0:       return 1;
            1:       return 2;
            default: return 4;
        endcase
    endfunction

    function automatic mem_read_req mk_rd(input logic [31:0] a);
        mem_read_req r;
        r = '0;
        r.valid = 1'b1;
        r.addr  = a;
        r.size  = 2'd2;
        return r;
    endfunction

    function automatic mem_write_req mk_wr(input logic [31:0] a, input word_t d, input logic [3:0] s);
        mem_write_req w;
        w = '0;
        w.valid  = 1'b1;
        w.addr   = a;
        w.size   = 2'd2;
        w.data   = d;
        w.strobe = s;
        return w;
    endfunction

    function automatic bit is_oor(input logic [31:0] a);
`ifdef DMEM_OOR_ERR_EN
        return a >= 4 * WORDS;
`else
        return (a == 32'h0) && 1'b0;
`endif
    endfunction

    function automatic int mkey(input int u, input logic [31:0] a);
        return u * 4096 + int'((a / 4) % WORDS);
    endfunction

    // Reference: a write updates strobed bytes; a lone in-range read refreshes the last read value.
    task automatic model_apply(input int u, input mem_read_req r, input mem_write_req w);
        word_t cur;
        int    k;
        if (w.valid) begin
            if (!is_oor(w.addr)) begin
                k   = mkey(u, w.addr);
                cur = mdl.exists(k) ? mdl[k] : 32'h0;
                for (int i = 0; i < 4; i++) begin
                    if (w.strobe[i]) cur[8*i +: 8] = w.data[8*i +: 8];
                end
                mdl[k] = cur;
            end
        end else if (r.valid && !is_oor(r.addr)) begin
            k = mkey(u, r.addr);
            rd_last[u] = mdl.exists(k) ? mdl[k] : 32'h0;
        end
    endtask

    // Drives one request to completion and reports what was observed.
    task automatic run_txn(input int u, input mem_read_req r, input mem_write_req w, input int hold,
                           output int n_stall, output word_t rd_resp, output logic held_ok,
                           output logic err_resp);
        int guard;
        guard   = 0;
        n_stall = 0;
        held_ok = 1'b1;
        @(posedge clk); #1;
        mread_s[u]   = r;
        mwrite_s[u]  = w;
        advance_s[u] = 1'b0;
        @(negedge clk);
        while (stall_s[u] && guard < 40) begin
            n_stall++;
            guard++;
            @(negedge clk);
        end
        rd_resp = rd_s[u];
`ifdef DMEM_OOR_ERR_EN
        err_resp = addr_err_s[u];
`else
        err_resp = 1'b0;
`endif
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            if (stall_s[u] || rd_s[u] !== rd_resp) held_ok = 1'b0;
        end
        advance_s[u] = 1'b1;
        @(posedge clk); #1;
        mread_s[u]   = '0;
        mwrite_s[u]  = '0;
        advance_s[u] = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        for (int u = 0; u < 3; u++) begin
            mread_s[u]   = '0;
            mwrite_s[u]  = '0;
            advance_s[u] = 1'b0;
            rd_last[u]   = 32'h0;
        end
        repeat (3) @(negedge clk);
        for (int u = 0; u < 3; u++) begin
            n_vec++;
            if (rd_s[u] !== 32'h0 || stall_s[u] !== 1'b0) begin
                n_err++;
                $display("FAIL reset u%0d: rd=%h stall=%b, want rd=0 stall=0", u, rd_s[u], stall_s[u]);
            end
`ifdef DMEM_OOR_ERR_EN
            n_vec++;
            if (addr_err_s[u] !== 1'b0) begin
                n_err++;
                $display("FAIL reset_addr_err u%0d: got %b want 0", u, addr_err_s[u]);
            end
`endif
        end
        @(posedge clk); #1;
        resetn = 1'b1;
    endtask

    task automatic test_write_read();
        int n; word_t d; logic h, e;
        run_txn(1, '0, mk_wr(32'h10, 32'hDEADBEEF, 4'b1111), 0, n, d, h, e);
        model_apply(1, '0, mk_wr(32'h10, 32'hDEADBEEF, 4'b1111));
        n_vec++;
        if (n !== 2) begin
            n_err++;
            $display("FAIL write_stall: got %0d cycles want 2", n);
        end
        run_txn(1, mk_rd(32'h10), '0, 0, n, d, h, e);
        model_apply(1, mk_rd(32'h10), '0);
        n_vec++;
        if (n !== 2 || d !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL read_back: stall=%0d rd=%h want stall=2 rd=deadbeef", n, d);
        end
    endtask

    task automatic test_partial_strobe();
        int n; word_t d; logic h, e;
        run_txn(1, '0, mk_wr(32'h20, 32'h11223344, 4'b1111), 0, n, d, h, e);
        model_apply(1, '0, mk_wr(32'h20, 32'h11223344, 4'b1111));
        run_txn(1, '0, mk_wr(32'h20, 32'hAABBCCDD, 4'b0101), 0, n, d, h, e);
        model_apply(1, '0, mk_wr(32'h20, 32'hAABBCCDD, 4'b0101));
        run_txn(1, mk_rd(32'h20), '0, 0, n, d, h, e);
        model_apply(1, mk_rd(32'h20), '0);
        n_vec++;
        if (d !== 32'h11BB33DD || d !== rd_last[1]) begin
            n_err++;
            $display("FAIL partial_strobe: got %h want 11bb33dd (model %h)", d, rd_last[1]);
        end
    endtask

    task automatic test_flush();
        int n; word_t d; logic h, e;
        run_txn(2, '0, mk_wr(32'h40, 32'h01020304, 4'b1111), 0, n, d, h, e);
        model_apply(2, '0, mk_wr(32'h40, 32'h01020304, 4'b1111));
        @(posedge clk); #1;
        mwrite_s[2] = mk_wr(32'h40, 32'hFFFFFFFF, 4'b1111);
        repeat (2) begin
            @(posedge clk); #1;
        end
        mwrite_s[2] = '0;
        @(negedge clk);
        n_vec++;
        if (stall_s[2] !== 1'b0) begin
            n_err++;
            $display("FAIL flush_stall: got %b want 0", stall_s[2]);
        end
        run_txn(2, mk_rd(32'h40), '0, 0, n, d, h, e);
        model_apply(2, mk_rd(32'h40), '0);
        n_vec++;
        if (n !== 4 || d !== 32'h01020304) begin
            n_err++;
            $display("FAIL flush_old_value: stall=%0d rd=%h want stall=4 rd=01020304", n, d);
        end
    endtask

    task automatic test_hold();
        int n; word_t d; logic h, e;
        run_txn(1, mk_rd(32'h10), '0, 3, n, d, h, e);
        model_apply(1, mk_rd(32'h10), '0);
        n_vec++;
        if (h !== 1'b1 || d !== 32'hDEADBEEF || n !== 2) begin
            n_err++;
            $display("FAIL hold: held_ok=%b rd=%h stall=%0d want 1 deadbeef 2", h, d, n);
        end
        run_txn(1, mk_rd(32'h20), '0, 0, n, d, h, e);
        model_apply(1, mk_rd(32'h20), '0);
        n_vec++;
        if (n !== 2 || d !== rd_last[1]) begin
            n_err++;
            $display("FAIL after_hold: stall=%0d rd=%h want 2 %h", n, d, rd_last[1]);
        end
    endtask

    task automatic test_simultaneous();
        int n; word_t d; logic h, e;
        run_txn(0, '0, mk_wr(32'h34, 32'hFFFF0000, 4'b1111), 0, n, d, h, e);
        model_apply(0, '0, mk_wr(32'h34, 32'hFFFF0000, 4'b1111));
        run_txn(0, mk_rd(32'h34), '0, 0, n, d, h, e);
        model_apply(0, mk_rd(32'h34), '0);
        run_txn(0, mk_rd(32'h30), mk_wr(32'h30, 32'h5, 4'b1111), 0, n, d, h, e);
        model_apply(0, mk_rd(32'h30), mk_wr(32'h30, 32'h5, 4'b1111));
        n_vec++;
        if (n !== 1 || d !== 32'hFFFF0000) begin
            n_err++;
            $display("FAIL simul_write_wins: stall=%0d rd=%h want 1 ffff0000", n, d);
        end
        run_txn(0, mk_rd(32'h30), '0, 0, n, d, h, e);
        model_apply(0, mk_rd(32'h30), '0);
        n_vec++;
        if (n !== 1 || d !== 32'h5) begin
            n_err++;
            $display("FAIL simul_read_back: stall=%0d rd=%h want 1 00000005", n, d);
        end
    endtask

    task automatic test_out_of_range();
        int n; word_t d; logic h, e;
`ifdef DMEM_OOR_ERR_EN
        run_txn(1, mk_rd(32'h1000), '0, 1, n, d, h, e);
        model_apply(1, mk_rd(32'h1000), '0);
        n_vec++;
        if (n !== 2 || d !== rd_last[1] || e !== 1'b1) begin
            n_err++;
            $display("FAIL oor_flag: stall=%0d rd=%h err=%b want 2 %h 1", n, d, e, rd_last[1]);
        end
        @(negedge clk);
        n_vec++;
        if (addr_err_s[1] !== 1'b0) begin
            n_err++;
            $display("FAIL oor_clear: got %b want 0", addr_err_s[1]);
        end
`else
        run_txn(1, '0, mk_wr(32'h0, 32'h0BADF00D, 4'b1111), 0, n, d, h, e);
        model_apply(1, '0, mk_wr(32'h0, 32'h0BADF00D, 4'b1111));
        run_txn(1, mk_rd(32'h1000), '0, 0, n, d, h, e);
        model_apply(1, mk_rd(32'h1000), '0);
        n_vec++;
        if (n !== 2 || d !== 32'h0BADF00D) begin
            n_err++;
            $display("FAIL oor_wrap: stall=%0d rd=%h want 2 0badf00d", n, d);
        end
`endif
    endtask

    task automatic test_reset_mid_wait();
        int n; word_t d; logic h, e;
        @(posedge clk); #1;
        mwrite_s[2] = mk_wr(32'h40, 32'hCAFEF00D, 4'b1111);
        repeat (2) begin
            @(posedge clk); #1;
        end
        resetn      = 1'b0;
        mwrite_s[2] = '0;
        #2;
        for (int u = 0; u < 3; u++) begin
            rd_last[u] = 32'h0;
            n_vec++;
            if (rd_s[u] !== 32'h0 || stall_s[u] !== 1'b0) begin
                n_err++;
                $display("FAIL reset_mid_wait u%0d: rd=%h stall=%b want 0 0", u, rd_s[u], stall_s[u]);
            end
        end
        @(posedge clk); #1;
        resetn = 1'b1;
        run_txn(2, mk_rd(32'h40), '0, 0, n, d, h, e);
        model_apply(2, mk_rd(32'h40), '0);
        n_vec++;
        if (n !== 4 || d !== 32'h01020304) begin
            n_err++;
            $display("FAIL reset_array_kept: stall=%0d rd=%h want 4 01020304", n, d);
        end
    endtask

    task automatic test_random();
        int n; word_t d; logic h, e;
        mem_read_req  r;
        mem_write_req w;
        logic [31:0]  a;
        int           kind;
        for (int u = 0; u < 3; u++) begin
            for (int p = 0; p < 8; p++) begin
                w = mk_wr(32'h100 + 32'(4 * p), $urandom, 4'b1111);
                run_txn(u, '0, w, 0, n, d, h, e);
                model_apply(u, '0, w);
            end
            for (int t = 0; t < 25; t++) begin
                a = 32'h100 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
`ifndef DMEM_OOR_ERR_EN
                a = a + (32'($urandom_range(0, 7)) << 12);
`endif
                kind = $urandom_range(0, 2);
                r = (kind != 1) ? mk_rd(32'h100 + 32'(4 * $urandom_range(0, 7))) : '0;
                w = (kind != 0) ? mk_wr(a, $urandom, 4'($urandom_range(0, 15))) : '0;
                if (kind == 0) r.addr = a;
                run_txn(u, r, w, $urandom_range(0, 2), n, d, h, e);
                model_apply(u, r, w);
                n_vec++;
                if (n !== lat_of(u) || d !== rd_last[u] || h !== 1'b1) begin
                    n_err++;
                    $display("FAIL random u%0d t%0d kind%0d: stall=%0d rd=%h held=%b want %0d %h 1",
                             u, t, kind, n, d, h, lat_of(u), rd_last[u]);
                end
            end
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_write_read();
        test_partial_strobe();
        test_flush();
        test_hold();
        test_simultaneous();
        test_out_of_range();
        test_reset_mid_wait();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
